mem_responder: RTL and testbench

MEM_RESPONDER -- requirements
Module: mem_responder

---
 rtl/mem_responder.sv | 139 +++++++++++++
 tb/tb_mem_responder.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_responder.sv
// Fixed-latency word memory that answers single read/write requests from the control FSM.
// The request is captured once and completes after LATENCY cycles, followed by a one-cycle recovery.
module mem_responder #(
    parameter int unsigned LATENCY = 4,
    parameter int unsigned AW      = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mio_en,
    input  logic        r_w,
    input  logic        data_size,
    input  logic [15:0] mar,
    input  logic [15:0] mdr_in,
    output logic [15:0] mem_data,
    output logic        r,
    output logic        err,
    output logic [1:0]  state_o
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY    = 2'd1,
        DONE    = 2'd2,
        RECOVER = 2'd3
    } state_e;

    localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

    logic [15:0]   mem_q [0:(2**AW)-1];

    state_e        state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic [AW:0]   addr_q, addr_d;
    logic [15:0]   wdata_q, wdata_d;
    logic          rw_q, rw_d;
    logic          size_q, size_d;
    logic [15:0]   rdata_q, rdata_d;
    logic          r_q, r_d;
    logic          err_q, err_d;

    logic [AW-1:0] idx;
    logic          complete;
    logic          mem_we;
    logic [1:0]    byte_en;
    logic [15:0]   mem_wdata;
    logic          unused_mar_hi;

    // Address bits above the storage size are dropped, so addresses wrap.
    assign unused_mar_hi = ^mar[15:AW+1];

    assign idx      = addr_q[AW:1];
    assign complete = (state_q == BUSY) && (cnt_q == 4'd0);
    // A reset on the completing edge must suppress the write as well as r.
    assign mem_we   = reset && complete && rw_q;

    always_comb begin
        byte_en   = 2'b11;
        mem_wdata = wdata_q;
        if (!size_q) begin
            // Byte data always arrives in the low lane and is steered by mar[0].
            mem_wdata = {wdata_q[7:0], wdata_q[7:0]};
            byte_en   = addr_q[0] ? 2'b10 : 2'b01;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            if (byte_en[0]) mem_q[idx][7:0]  <= mem_wdata[7:0];
            if (byte_en[1]) mem_q[idx][15:8] <= mem_wdata[15:8];
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            addr_q  <= '0;
            wdata_q <= 16'h0000;
            rw_q    <= 1'b0;
            size_q  <= 1'b0;
            rdata_q <= 16'h0000;
            r_q     <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rw_q    <= rw_d;
            size_q  <= size_d;
            rdata_q <= rdata_d;
            r_q     <= r_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rw_d    = rw_q;
        size_d  = size_q;
        rdata_d = rdata_q;
        r_d     = 1'b0;
        err_d   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (mio_en) begin
                    addr_d  = mar[AW:0];
                    wdata_d = mdr_in;
                    rw_d    = r_w;
                    size_d  = data_size;
                    cnt_d   = CNT_LOAD;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (cnt_q == 4'd0) begin
                    r_d     = 1'b1;
                    err_d   = size_q & addr_q[0];
                    state_d = DONE;
                    if (!rw_q) rdata_d = mem_q[idx];
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            DONE:    state_d = RECOVER;
            RECOVER: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign mem_data = rdata_q;
    assign r        = r_q;
    assign err      = err_q;
    assign state_o  = state_q;

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: a reference memory model fills an expected queue at capture time,
// and a negedge monitor pops and compares whenever r pulses.
module tb_mem_responder;

    localparam int LAT = 4;
    localparam int AW  = 10;

    logic        clk;
    logic        reset;
    logic        mio_en;
    logic        r_w;
    logic        data_size;
    logic [15:0] mar;
    logic [15:0] mdr_in;
    logic [15:0] mem_data;
    logic        r;
    logic        err;
    logic [1:0]  state_o;

    mem_responder #(.LATENCY(LAT), .AW(AW)) dut (
        .clk       (clk),
        .reset     (reset),
        .mio_en    (mio_en),
        .r_w       (r_w),
        .data_size (data_size),
        .mar       (mar),
        .mdr_in    (mdr_in),
        .mem_data  (mem_data),
        .r         (r),
        .err       (err),
        .state_o   (state_o)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // scoreboard state
    logic [15:0] exp_q[$];
    logic        exp_err_q[$];
    int          exp_cyc_q[$];
    logic [15:0] model [0:(2**AW)-1];
    logic [15:0] last_rd;
    int          checks   = 0;
    int          failures = 0;
    logic        r_prev   = 1'b0;

    // monitor: compares every r pulse against the head of the expected queue
    always @(negedge clk) begin
        if (r === 1'b1) begin
            checks++;
            if (r_prev === 1'b1) begin
                failures++;
                $display("FAIL r_adjacent cyc=%0d got two consecutive r cycles, required a gap", cyc);
            end
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_r cyc=%0d got r=1 with mem_data=%h, required no pulse", cyc, mem_data);
            end else begin
                logic [15:0] ed;
                logic        ee;
                int          ec;
                ed = exp_q.pop_front();
                ee = exp_err_q.pop_front();
                ec = exp_cyc_q.pop_front();
                checks++;
                if (cyc !== ec) begin
                    failures++;
                    $display("FAIL r_latency got cycle %0d required cycle %0d", cyc, ec);
                end
                checks++;
                if (mem_data !== ed) begin
                    failures++;
                    $display("FAIL mem_data cyc=%0d got %h required %h", cyc, mem_data, ed);
                end
                checks++;
                if (err !== ee) begin
                    failures++;
                    $display("FAIL err cyc=%0d got %b required %b", cyc, err, ee);
                end
            end
        end
        r_prev = r;
    end

    // Reference model: apply the request and push what the DUT must report.
    task automatic model_req(input logic rw, input logic size, input logic [15:0] addr,
                             input logic [15:0] data, input int r_cyc);
        logic [AW-1:0] i;
        i = addr[AW:1];
        if (rw) begin
            if (size)          model[i] = data;
            else if (addr[0])  model[i][15:8] = data[7:0];
            else               model[i][7:0]  = data[7:0];
        end else begin
            last_rd = model[i];
        end
        exp_q.push_back(last_rd);
        exp_err_q.push_back(size & addr[0]);
        exp_cyc_q.push_back(r_cyc);
    endtask

    // After r, the DUT spends one cycle in DONE and one in RECOVER before accepting again.
    task automatic wait_done();
        bit seen;
        seen = 1'b0;
        for (int n = 0; n < 64 && !seen; n++) begin
            @(negedge clk);
            if (r === 1'b1) seen = 1'b1;
        end
        if (!seen) begin
            checks++;
            failures++;
            $display("FAIL wait_done_timeout got no r within 64 cycles, required a pulse");
        end
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic do_req(input logic rw, input logic size, input logic [15:0] addr,
                          input logic [15:0] data);
        int cap;
        @(negedge clk);
        r_w = rw; data_size = size; mar = addr; mdr_in = data; mio_en = 1'b1;
        @(negedge clk);
        cap = cyc;
        mio_en = 1'b0;
        // scramble inputs: the latched copy must be used
        r_w = ~rw; data_size = ~size; mar = 16'($urandom); mdr_in = 16'($urandom);
        model_req(rw, size, addr, data, cap + LAT);
        wait_done();
    endtask

    task automatic test_reset();
        reset = 1'b0; mio_en = 1'b0; r_w = 1'b0; data_size = 1'b0; mar = '0; mdr_in = '0;
        last_rd = 16'h0000;
        repeat (3) @(negedge clk);
        checks++;
        if (mem_data !== 16'h0000) begin failures++; $display("FAIL reset_mem_data got %h required 0000", mem_data); end
        checks++;
        if (r !== 1'b0) begin failures++; $display("FAIL reset_r got %b required 0", r); end
        checks++;
        if (err !== 1'b0) begin failures++; $display("FAIL reset_err got %b required 0", err); end
        reset = 1'b1;
    endtask

    task automatic test_word_rw();
        do_req(1'b1, 1'b1, 16'h0010, 16'hBEEF);
        do_req(1'b0, 1'b1, 16'h0010, 16'h0000);
    endtask

    task automatic test_byte_merge();
        do_req(1'b1, 1'b1, 16'h0020, 16'h1234);
        do_req(1'b1, 1'b0, 16'h0021, 16'h00AB);
        do_req(1'b0, 1'b1, 16'h0020, 16'h0000);
        do_req(1'b1, 1'b0, 16'h0020, 16'h55CD);
        do_req(1'b0, 1'b0, 16'h0021, 16'h0000);
    endtask

    task automatic test_misaligned();
        do_req(1'b0, 1'b1, 16'h0011, 16'h0000);
        do_req(1'b1, 1'b1, 16'h0031, 16'h7777);
        do_req(1'b0, 1'b1, 16'h0030, 16'h0000);
    endtask

    task automatic test_back_to_back();
        int cap;
        bit ok;
        @(negedge clk);
        r_w = 1'b0; data_size = 1'b1; mar = 16'h0010; mio_en = 1'b1;
        @(negedge clk);
        cap = cyc;
        mar = 16'h0020;
        // r at cap+LAT, then DONE, RECOVER, and recapture on the edge closing the IDLE cycle
        model_req(1'b0, 1'b1, 16'h0010, 16'h0000, cap + LAT);
        model_req(1'b0, 1'b1, 16'h0020, 16'h0000, cap + 2 * LAT + 3);
        ok = 1'b0;
        for (int n = 0; n < 64 && !ok; n++) begin
            if (cyc >= cap + LAT + 3) ok = 1'b1;
            else @(negedge clk);
        end
        mio_en = 1'b0;
        wait_done();
    endtask

    task automatic test_reset_abort();
        do_req(1'b1, 1'b1, 16'h0040, 16'h5555);
        @(negedge clk);
        r_w = 1'b1; data_size = 1'b1; mar = 16'h0040; mdr_in = 16'hFFFF; mio_en = 1'b1;
        @(negedge clk);
        mio_en = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        last_rd = 16'h0000;
        checks++;
        if (mem_data !== 16'h0000) begin failures++; $display("FAIL abort_mem_data got %h required 0000", mem_data); end
        checks++;
        if (r !== 1'b0) begin failures++; $display("FAIL abort_r got %b required 0", r); end
        repeat (8) @(negedge clk);
        do_req(1'b0, 1'b1, 16'h0040, 16'h0000);
    endtask

    task automatic test_wrap();
        do_req(1'b1, 1'b1, 16'h0802, 16'hC0DE);
        do_req(1'b0, 1'b1, 16'h0002, 16'h0000);
    endtask

    task automatic test_random();
        for (int i = 0; i < 8; i++)
            do_req(1'b1, 1'b1, 16'(16'h0100 + 2 * i), 16'($urandom));
        for (int i = 0; i < 20; i++)
            do_req(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                   16'(16'h0100 + $urandom_range(0, 15)), 16'($urandom));
    endtask

    initial begin
        test_reset();
        test_word_rw();
        test_byte_merge();
        test_misaligned();
        test_back_to_back();
        test_reset_abort();
        test_wrap();
        test_random();
        repeat (4) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL pending_expected got %0d outstanding required 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
